// File: rtl/tt_um_onboarding_ore_if.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_onboarding_ore_if
// Brief    : TinyTapeout tile pin bundle (inputs, outputs, bidir controls).
// Revision : 1.0
// ============================================================================
interface tt_um_onboarding_ore_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface
`default_nettype wire

// File: rtl/tt_um_onboarding_ore.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_onboarding_ore
// Brief    : SPI write-only register bank driving 16 static/PWM output channels.
// Revision : 1.0
// ============================================================================
module tt_um_onboarding_ore #(
    parameter int CLK_DIV  = 13,
    parameter int NUM_REGS = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    tt_um_onboarding_ore_if.slave  bus
);

    localparam int       c_PRESC_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [6:0] c_NUM_REGS_A = 7'(NUM_REGS);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CLK_DIV - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_sclk_sync;
    logic [1:0]  r_copi_sync;
    logic [1:0]  r_ncs_sync;
    logic        r_sclk_d;
    logic        r_ncs_d;

    logic        w_sclk_rise;
    logic        w_ncs_fall;
    logic        w_ncs_rise;

    logic [15:0] r_shift;
    logic [15:0] w_shift_nxt;
    logic [4:0]  r_bit_cnt;
    logic [4:0]  w_bit_cnt_nxt;
    logic        w_commit;
    logic [6:0]  w_addr;

    logic [15:0] r_en_out;
    logic [15:0] r_pwm_en;
    logic [7:0]  r_duty;

    logic [c_PRESC_W-1:0] r_presc;
    logic        w_tick;
    logic [7:0]  r_pwm_cnt;
    logic        w_pwm_sig;
    logic [15:0] w_out;

    logic        w_unused;

    // Pin synchronizers plus one extra stage on SCLK/nCS for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_sync <= 2'b00;
            r_copi_sync <= 2'b00;
            r_ncs_sync  <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], bus.ui_in[0]};
            r_copi_sync <= {r_copi_sync[0], bus.ui_in[1]};
            r_ncs_sync  <= {r_ncs_sync[0],  bus.ui_in[2]};
            r_sclk_d    <= r_sclk_sync[1];
            r_ncs_d     <= r_ncs_sync[1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_ncs_fall  = ~r_ncs_sync[1] & r_ncs_d;
    assign w_ncs_rise  = r_ncs_sync[1] & ~r_ncs_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= 16'h0000;
            r_bit_cnt <= 5'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    // Bit counter saturates so an over-long frame can never alias back to 16
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_commit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ncs_fall) begin
                    w_state_nxt   = S_FRAME;
                    w_shift_nxt   = 16'h0000;
                    w_bit_cnt_nxt = 5'd0;
                end
            end
            S_FRAME: begin
                if (w_ncs_rise) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = (r_bit_cnt == 5'd16) && r_shift[15] &&
                                  (r_shift[14:8] < c_NUM_REGS_A);
                end else if (w_sclk_rise && !r_ncs_sync[1]) begin
                    w_shift_nxt = {r_shift[14:0], r_copi_sync[1]};
                    if (r_bit_cnt != 5'h1F) begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_addr = r_shift[14:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en_out <= 16'h0000;
            r_pwm_en <= 16'h0000;
            r_duty   <= 8'h00;
        end else if (w_commit) begin
            case (w_addr)
                7'd0:    r_en_out[7:0]  <= r_shift[7:0];
                7'd1:    r_en_out[15:8] <= r_shift[7:0];
                7'd2:    r_pwm_en[7:0]  <= r_shift[7:0];
                7'd3:    r_pwm_en[15:8] <= r_shift[7:0];
                7'd4:    r_duty         <= r_shift[7:0];
                default: ;
            endcase
        end
    end

    assign w_tick = (r_presc == c_PRESC_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= 8'h00;
        end else if (w_tick) begin
            r_presc   <= '0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_presc   <= r_presc + c_PRESC_W'(1);
        end
    end

    // 0xFF is forced fully on, since pwm_cnt < 0xFF would leave one step low
    assign w_pwm_sig = (r_duty == 8'hFF) ? 1'b1 : (r_pwm_cnt < r_duty);

    assign w_out = r_en_out & (~r_pwm_en | {16{w_pwm_sig}});

    assign bus.uo_out  = w_out[7:0];
    assign bus.uio_out = w_out[15:8];
    assign bus.uio_oe  = 8'hFF;

    assign w_unused = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:3]};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_onboarding_ore.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized SPI frames against a register/PWM reference model with a scoreboard.
module tb_tt_um_onboarding_ore;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    typedef struct {
        logic [15:0] en;
        logic [15:0] pe;
        logic [7:0]  duty;
        int          kind;
    } item_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic copi  = 1'b0;
    logic ncs   = 1'b1;

    int n_cmp  = 0;
    int n_bad  = 0;
    int k_cyc  = 0;
    int pushed = 0;
    int done   = 0;

    logic [7:0] m_reg [5];
    item_t      sb_q [$];

    tt_um_onboarding_ore_if bus_if ();

    assign bus_if.ena    = 1'b1;
    assign bus_if.uio_in = 8'h00;
    assign bus_if.ui_in  = {5'b00000, ncs, copi, sclk};

    tt_um_onboarding_ore #(.CLK_DIV(CLK_DIV), .NUM_REGS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #50 clk = ~clk;

    // Non-reset clock edges since the last reset edge define the PWM phase
    always @(posedge clk) begin
        if (!rst_n) k_cyc <= 0;
        else        k_cyc <= k_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_out(input item_t it, input int kk);
        int   cnt;
        logic sig;
        cnt = (kk / CLK_DIV) % 256;
        sig = (it.duty == 8'hFF) ? 1'b1 : (cnt < int'(it.duty));
        return it.en & (~it.pe | {16{sig}});
    endfunction

    function automatic int exp_high(input item_t it, input int ch);
        if (!it.en[ch]) return 0;
        if (!it.pe[ch]) return PERIOD;
        if (it.duty == 8'hFF) return PERIOD;
        return int'(it.duty) * CLK_DIV;
    endfunction

    // Monitor: pops one expectation per issued stimulus and checks the outputs
    initial begin : mon
        item_t       it;
        int          h0, h8, wbad;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                it = sb_q.pop_front();
                repeat (5) @(negedge clk);
                if (it.kind == 0) begin
                    for (int j = 0; j < 3; j++) begin
                        e = model_out(it, k_cyc);
                        check("point_out", 32'({bus_if.uio_out, bus_if.uo_out}), 32'(e));
                        check("point_oe", 32'(bus_if.uio_oe), 32'h000000FF);
                        repeat ($urandom_range(1, 300)) @(negedge clk);
                    end
                end else begin
                    h0 = 0; h8 = 0; wbad = 0;
                    for (int c = 0; c < PERIOD; c++) begin
                        if (bus_if.uo_out[0])  h0++;
                        if (bus_if.uio_out[0]) h8++;
                        if ({bus_if.uio_out, bus_if.uo_out} !== model_out(it, k_cyc)) wbad++;
                        @(negedge clk);
                    end
                    check("win_high_ch0", 32'(h0), 32'(exp_high(it, 0)));
                    check("win_high_ch8", 32'(h8), 32'(exp_high(it, 8)));
                    check("win_model_errs", 32'(wbad), 32'd0);
                end
                done++;
            end
        end
    end

    task automatic push(input int kind);
        item_t it;
        int    t;
        it.en   = {m_reg[1], m_reg[0]};
        it.pe   = {m_reg[3], m_reg[2]};
        it.duty = m_reg[4];
        it.kind = kind;
        sb_q.push_back(it);
        pushed++;
        t = 0;
        while (done != pushed && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (done != pushed) begin
            n_cmp++;
            n_bad++;
            $display("FAIL monitor_timeout: got done=%0d expected %0d", done, pushed);
        end
    endtask

    task automatic spi_frame(input logic [15:0] d, input int nbits);
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            copi = (b < 16) ? d[15-b] : 1'($urandom_range(0, 1));
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        if (nbits == 16 && d[15] && int'(d[14:8]) < 5)
            m_reg[int'(d[14:8])] = d[7:0];
    endtask

    initial begin : drv
        int          nz;
        int          sel;
        logic [15:0] fr;
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;

        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_uo", 32'(bus_if.uo_out), 32'h0);
        check("rst_uio", 32'(bus_if.uio_out), 32'h0);
        check("rst_oe", 32'(bus_if.uio_oe), 32'hFF);
        rst_n = 1'b1;
        nz = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if ({bus_if.uio_out, bus_if.uo_out} !== 16'h0000) nz++;
        end
        check("idle_quiet", 32'(nz), 32'd0);

        spi_frame(16'h80F0, 16);
        spi_frame(16'h81CC, 16);
        push(0);
        spi_frame(16'h0055, 16);  push(0);
        spi_frame(16'hB0AA, 16);  push(0);
        spi_frame(16'h80FF, 12);  push(0);
        spi_frame(16'h8133, 17);  push(0);

        spi_frame(16'h8001, 16);
        spi_frame(16'h8201, 16);
        spi_frame(16'h8480, 16);
        push(1);
        spi_frame(16'h8400, 16);  push(1);
        spi_frame(16'h84FF, 16);  push(1);

        spi_frame(16'h80FF, 16);
        spi_frame(16'h81FF, 16);
        spi_frame(16'h8200, 16);
        spi_frame(16'h83FF, 16);
        spi_frame(16'h8440, 16);
        push(1);

        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 6);
            fr  = 16'($urandom);
            case (sel)
                0, 1, 2: begin
                    fr[15] = 1'b1;
                    fr[14:8] = 7'($urandom_range(0, 4));
                    spi_frame(fr, 16);
                end
                3: begin
                    fr[15] = 1'b1;
                    spi_frame(fr, 16);
                end
                4: begin
                    fr[15] = 1'b0;
                    spi_frame(fr, 16);
                end
                default: begin
                    fr[15] = 1'b1;
                    fr[14:8] = 7'($urandom_range(0, 4));
                    spi_frame(fr, ($urandom_range(0, 1) == 0) ? $urandom_range(1, 15)
                                                                : $urandom_range(17, 20));
                end
            endcase
            push((n % 10 == 9) ? 1 : 0);
        end

        spi_frame(16'h80A5, 16);
        spi_frame(16'h8484, 16);
        push(0);
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            copi = 1'b1;
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_uo", 32'(bus_if.uo_out), 32'h0);
        ncs  = 1'b1;
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        push(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_um_onboarding_ore.md
Name: tt_um_onboarding_ore

Overview:
TinyTapeout user tile combining a write-only SPI register bank with a 16-channel PWM/static output stage. An external SPI controller writes five 8-bit control registers. These registers select, per output bit, whether the bit is off, statically high, or driven by a shared ~3 kHz PWM waveform. Outputs appear on uo_out[7:0] (channels 7..0) and uio_out[7:0] (channels 15..8).

Parameters:
CLK_DIV, 13, system clocks per PWM counter step (10 MHz clk -> 10e6/(13*256) ≈ 3005 Hz PWM)
NUM_REGS, 5, number of implemented register addresses (0x00..0x04)

Ports:
clk  input  1  system clock (10 MHz nominal), all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
ena  input  1  tile enable; ignored
ui_in  input  8  [0]=SCLK, [1]=COPI, [2]=nCS; [7:3] unused
uo_out  output  8  output channels 7..0
uio_in  input  8  unused
uio_out  output  8  output channels 15..8
uio_oe  output  8  constant 8'hFF (all uio pins are outputs)

Behaviour:
- Reset (rst_n=0 at clk edge): all registers = 0x00, synchronizers cleared, SPI bit counter = 0, PWM counters = 0. uo_out = uio_out = 0x00. uio_oe = 0xFF at all times.
- Register map (write-only):
  - 0x00 en_out[7:0], 0x01 en_out[15:8]: output enable per channel.
  - 0x02 pwm_en[7:0], 0x03 pwm_en[15:8]: PWM mode per channel.
  - 0x04 duty[7:0]: shared duty cycle.
- SPI input path: SCLK, COPI and nCS each pass through a 2-flop synchronizer to clk. Edge detection runs on the synchronized SCLK.
- SPI mode 0, MSB first, 16-bit frame:
  - bit15 = R/W (1 = write).
  - bits14:8 = 7-bit address.
  - bits7:0 = data.
- Frame handling:
  - Falling edge of synchronized nCS starts a frame and clears the bit counter and shift register.
  - While nCS is low, each rising SCLK edge shifts COPI into the LSB and increments the count.
  - Rising edge of nCS ends the frame.
- Commit rule: at frame end, if exactly 16 bits were received, R/W = 1 and address <= 0x04, write data to the addressed register in that cycle. Otherwise discard the frame (reads, address >= 0x05, short or long frames).
- SCLK edges while nCS is high are ignored.
- Reset asserted mid-frame aborts the frame; no register changes except clearing.
- PWM timebase:
  - A prescaler counts 0..CLK_DIV-1 and emits a one-cycle tick at wrap.
  - An 8-bit pwm_cnt increments on each tick, wrapping 255->0.
  - Period = 256*CLK_DIV clocks = 3328 clocks.
- pwm_sig:
  - duty = 0xFF -> constant 1.
  - duty = 0x00 -> constant 0.
  - otherwise pwm_sig = (pwm_cnt < duty); high for duty*CLK_DIV clocks per period.
- Per channel i (0..15), combinational from registered state:
  - out[i] = 0 if en_out[i] = 0.
  - out[i] = 1 if en_out[i] = 1 and pwm_en[i] = 0.
  - out[i] = pwm_sig if en_out[i] = 1 and pwm_en[i] = 1.
- Output mapping: uo_out = out[7:0], uio_out = out[15:8].
- A duty change takes effect from the next clock. The PWM counter is not restarted by register writes.
- Latency: a register write is visible on outputs 1 clk after the synchronized nCS rise, i.e. ≤ 4 clk after the nCS pin rises.

Test Plan:
- Reset: hold rst_n=0 for 5 clk -> uo_out=0x00, uio_out=0x00, uio_oe=0xFF; no toggling for 10000 clk.
- Static enable: write 0x00<=0xF0 (frame 0x80F0), then 0x01<=0xCC (0x81CC) -> uo_out=0xF0, uio_out=0xCC steady.
- Invalid frames:
  - read frame 0x0055 -> outputs unchanged.
  - write to address 0x30 (frame 0xB0AA) -> outputs unchanged.
  - 12-bit aborted frame -> no change.
- PWM 50%: write en_out[0]=1 (0x8001), pwm_en[0]=1 (0x8201), duty=0x80 (0x8480) -> uo_out[0] period 3328±13 clk (~3005 Hz); high time 1664±13 clk.
- Duty extremes: duty=0x00 -> uo_out[0] constant 0 over 3 periods; duty=0xFF -> constant 1 over 3 periods.
- Mixed channels: en_out=0xFFFF, pwm_en[15:8]=0xFF, duty=0x40 -> uo_out=0xFF static; uio_out toggles all-together with 25% duty (832±13 high clk per 3328).
